// File: rtl/stuffed_frame_tx.sv
// stuffed_frame_tx: serial frame transmitter for "111" sequence detectors.
// A frame is a preamble of three 1s, a 0 separator, WIDTH payload bits sent
// MSB-first with a 0 stuffed after every two consecutive 1s (while payload
// bits remain), and a trailing 0 guard. The stuffing means the preamble is
// the only "111" run on the line.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   start  frame request, accepted only while ready=1
//   data   payload, captured on the accepting edge
//   ready  idle, able to accept start
//   out    serial line bit (registered)
//   valid  out carries a frame bit (registered)
//   done   one-cycle pulse in the first idle cycle after the guard bit
module stuffed_frame_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out,
  output logic             valid,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StSep   = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StStuff = 3'd4;
  localparam logic [2:0] StGuard = 3'd5;

  // state_q names the state whose bit is currently on out.
  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [1:0]       ones_q, ones_d;
  logic [1:0]       pre_q, pre_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic msb;
  assign msb = shreg_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    ones_d   = ones_q;
    pre_d    = pre_q;
    out_d    = out_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
        if (start) begin
          state_d  = StPre;
          shreg_d  = data;
          bitcnt_d = '0;
          ones_d   = 2'd0;
          pre_d    = 2'd1;
          out_d    = 1'b1;
          valid_d  = 1'b1;
          ready_d  = 1'b0;
        end
      end

      StPre: begin
        if (pre_q == 2'd3) begin
          state_d = StSep;
          out_d   = 1'b0;
          ones_d  = 2'd0;
        end else begin
          pre_d = pre_q + 2'd1;
          out_d = 1'b1;
        end
      end

      // Both leave the ones counter at zero, so the run restarts at this bit.
      StSep, StStuff: begin
        state_d  = StData;
        out_d    = msb;
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + CW'(1);
        ones_d   = msb ? 2'd1 : 2'd0;
      end

      StData: begin
        if (bitcnt_q == LastBit) begin
          // Last payload bit is out: guard follows, never a stuff bit.
          state_d = StGuard;
          out_d   = 1'b0;
        end else if (ones_q == 2'd2) begin
          state_d = StStuff;
          out_d   = 1'b0;
          ones_d  = 2'd0;
        end else begin
          out_d    = msb;
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + CW'(1);
          ones_d   = msb ? ones_q + 2'd1 : 2'd0;
        end
      end

      StGuard: begin
        state_d = StIdle;
        out_d   = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end

      default: begin
        state_d = StIdle;
        out_d   = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      ones_q   <= 2'd0;
      pre_q    <= 2'd0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      ones_q   <= ones_d;
      pre_q    <= pre_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_stuffed_frame_tx.sv
// Bench for stuffed_frame_tx: a frame-level model (expected bit list built from
// the framing/stuffing rules) is checked against the DUT every cycle, plus
// literal frame images for the directed cases.
module tb_stuffed_frame_tx;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data;
  logic         ready, out, valid, done;

  stuffed_frame_tx #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .data (data),
    .ready(ready),
    .out  (out),
    .valid(valid),
    .done (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: what the outputs must show this cycle, and the frame bits still due.
  logic m_out = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_ready = 1'b1;
  bit   m_ok = 1'b0;
  bit   pend[$];

  // Frames observed on the line (oldest first), bit 0 = last bit sent.
  logic [31:0] cur_v = '0;
  int          cur_n = 0;
  logic [31:0] fr_v[$];
  int          fr_n[$];
  int          seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // Frame image from the rules: 111, 0, payload MSB-first with a 0 after
  // every second consecutive 1 when payload bits remain, then a 0 guard.
  task automatic build_frame(input logic [W-1:0] d, output logic [31:0] v, output int n);
    bit q[$];
    int run;
    for (int i = 0; i < 3; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    run = 0;
    for (int i = W - 1; i >= 0; i--) begin
      q.push_back(d[i]);
      run = d[i] ? run + 1 : 0;
      if (run == 2 && i > 0) begin
        q.push_back(1'b0);
        run = 0;
      end
    end
    q.push_back(1'b0);
    v = '0;
    n = q.size();
    foreach (q[k]) v = {v[30:0], q[k]};
  endtask

  function automatic int count111(input logic [31:0] v, input int n);
    int c = 0;
    for (int i = 0; i + 2 < n; i++) if (v[i+:3] == 3'b111) c++;
    return c;
  endfunction

  // One clock: compare at negedge, record, advance model, return at posedge+1.
  task automatic step();
    logic [31:0] fv;
    int          fn;
    @(negedge clk);
    if (m_ok) check("cycle {out,valid,done,ready}", {28'd0, out, valid, done, ready},
                    {28'd0, m_out, m_valid, m_done, m_ready});
    if (valid === 1'b1) begin
      cur_v = {cur_v[30:0], out};
      cur_n++;
    end else begin
      if (done === 1'b1) begin
        fr_v.push_back(cur_v);
        fr_n.push_back(cur_n);
        check("single 111 per frame", count111(cur_v, cur_n), 1);
      end
      cur_v = '0;
      cur_n = 0;
    end
    if (rst_n !== 1'b1) begin
      pend.delete();
      {m_out, m_valid, m_done, m_ready} = 4'b0001;
      m_ok = 1'b1;
    end else if (m_valid) begin
      if (pend.size() > 0) begin
        m_out = pend.pop_front();
      end else begin
        {m_out, m_valid, m_done, m_ready} = 4'b0011;
      end
    end else if (start === 1'b1) begin
      build_frame(data, fv, fn);
      for (int k = fn - 1; k >= 0; k--) pend.push_back(fv[k]);
      m_out = pend.pop_front();
      {m_valid, m_done, m_ready} = 3'b100;
    end else begin
      {m_out, m_valid, m_done, m_ready} = 4'b0001;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    for (int i = 0; i < 100 && ready !== 1'b1; i++) step();
    check("ready before send", ready, 1'b1);
    start = 1'b1;
    data  = d;
    step();
    start = 1'b0;
    data  = W'($urandom);
  endtask

  task automatic expect_frame(input string name, input logic [31:0] ev, input int en);
    for (int i = 0; i < 60 && fr_n.size() <= seen; i++) step();
    if (fr_n.size() <= seen) begin
      check({name, " frame timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " length"}, fr_n[seen], en);
      check({name, " bits"}, fr_v[seen], ev);
      seen++;
    end
  endtask

  initial begin
    logic [31:0] v;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;

    // Pin the model against hand-computed images.
    build_frame(8'h00, v, n); check("model 00 bits", v, 32'h1C00); check("model 00 len", n, 13);
    build_frame(8'hFF, v, n); check("model FF bits", v, 32'hEDB6); check("model FF len", n, 16);
    build_frame(8'hB6, v, n); check("model B6 bits", v, 32'h7598); check("model B6 len", n, 15);

    repeat (3) step();
    check("reset ready", ready, 1'b1);
    check("reset valid", valid, 1'b0);
    rst_n = 1'b1;
    step();

    send(8'h00); expect_frame("frame 00", 32'h1C00, 13);
    check("ready after frame", ready, 1'b1);
    send(8'hFF); expect_frame("frame FF", 32'hEDB6, 16);
    send(8'hB6); expect_frame("frame B6", 32'h7598, 15);

    // Back-to-back with ignored mid-frame starts.
    send(8'h03);
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      start = 1'($urandom_range(0, 1));
      data  = W'($urandom);
      step();
    end
    check("done seen for 03", done, 1'b1);
    start = 1'b1;
    data  = 8'hC0;
    step();
    start = 1'b0;
    check("b2b preamble out", out, 1'b1);
    check("b2b preamble valid", valid, 1'b1);
    expect_frame("frame 03", 32'h1C06, 13);
    expect_frame("frame C0", 32'h3B00, 14);

    // Reset during payload.
    send(8'hA5);
    repeat (6) step();
    rst_n = 1'b0;
    step();
    check("abort out", out, 1'b0);
    check("abort valid", valid, 1'b0);
    check("abort ready", ready, 1'b1);
    check("abort done", done, 1'b0);
    rst_n = 1'b1;
    repeat (20) step();
    check("no frame after abort", fr_n.size(), seen);
    send(8'hB6); expect_frame("frame B6 after abort", 32'h7598, 15);

    // Start held high: frames follow with one done cycle between them.
    start = 1'b1;
    data  = 8'h55;
    for (int i = 0; i < 100 && fr_n.size() < seen + 3; i++) step();
    start = 1'b0;
    for (int f = 0; f < 4; f++) expect_frame("frame 55", 32'h1CAA, 13);

    // Random traffic with rare resets; per-cycle model compare does the checking.
    for (int i = 0; i < 400; i++) begin
      start = 1'($urandom_range(0, 2) == 0);
      data  = W'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
